// File: rtl/contador_programa.sv
// Program counter for the fetch stage: sequential advance, branch redirects latched
// across memory wait and stall, and a sticky trap on misaligned redirect targets.
module contador_programa #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        salto_valido,
    input  logic [31:0] salto_destino,
    input  logic        stall,
    input  logic        mem_listo,
    output logic [31:0] pc_actual,
    output logic [31:0] pc_siguiente,
    output logic        solicitud,
    output logic        redireccion_pendiente,
    output logic        error_alineacion
);

    typedef enum logic [1:0] {
        INICIO   = 2'd0,
        BUSCAR   = 2'd1,
        DETENIDO = 2'd2,
        ERROR    = 2'd3
    } estado_t;

    estado_t     estado, estado_sig;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] objetivo;
    logic        es_salto;
    logic        aplicar;

    function automatic logic alineado(input logic [31:0] dir);
        return dir[1:0] == 2'b00;
    endfunction

    // Next address if the fetch were applied now: same-cycle redirect beats latched one.
    always_comb begin
        objetivo = pc_q + 32'd4;
        es_salto = 1'b0;
        if (salto_valido) begin
            objetivo = salto_destino;
            es_salto = 1'b1;
        end else if (pend_vld_q) begin
            objetivo = pend_q;
            es_salto = 1'b1;
        end
    end

    always_comb begin
        estado_sig = estado;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        aplicar    = 1'b0;

        case (estado)
            INICIO: estado_sig = BUSCAR;
            BUSCAR: begin
                if (mem_listo && !stall) begin
                    aplicar = 1'b1;
                end else begin
                    // A completed-but-stalled fetch defers its advance to DETENIDO.
                    if (mem_listo) estado_sig = DETENIDO;
                    if (salto_valido) begin
                        pend_d     = salto_destino;
                        pend_vld_d = 1'b1;
                    end
                end
            end
            DETENIDO: begin
                if (!stall) begin
                    aplicar = 1'b1;
                end else if (salto_valido) begin
                    pend_d     = salto_destino;
                    pend_vld_d = 1'b1;
                end
            end
            ERROR: estado_sig = ERROR;
            default: estado_sig = INICIO;
        endcase

        if (aplicar) begin
            pend_d     = 32'd0;
            pend_vld_d = 1'b0;
            if (es_salto && !alineado(objetivo)) begin
                estado_sig = ERROR;
            end else begin
                pc_d       = objetivo;
                estado_sig = BUSCAR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado     <= INICIO;
            pc_q       <= RESET_VECTOR;
            pend_q     <= 32'd0;
            pend_vld_q <= 1'b0;
        end else begin
            estado     <= estado_sig;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign pc_actual             = pc_q;
    assign pc_siguiente          = pc_q + 32'd4;
    assign solicitud             = (estado == BUSCAR);
    assign redireccion_pendiente = pend_vld_q;
    assign error_alineacion      = (estado == ERROR);

endmodule
